// File: rtl/muldiv_pkg.sv
// Shared types and default sizing for the multiply/divide sequencer.
package muldiv_pkg;

    localparam int MULDIV_WIDTH = 32;
    localparam int MULDIV_ITER  = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        RUN  = 2'b10,
        WB   = 2'b11
    } muldiv_state_t;

    function automatic logic isDiv(input muldiv_op_t op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_step_cnt.sv
// Loadable down-counter tracking the remaining datapath step cycles.
module muldiv_step_cnt
    import muldiv_pkg::*;
#(
    parameter int ITER = MULDIV_ITER
) (
    input  logic Clk,
    input  logic Reset,
    input  logic loadEn_i,
    input  logic decEn_i,
    output logic zero_o
);

    // A single-iteration build still needs a one-bit counter.
    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (loadEn_i) begin
            cnt_d = CW'(ITER - 1);
        end else if (decEn_i) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencer for the shared iterative multiply/divide datapath.
// Optional MULDIV_DIVZERO_TRAP_EN: divide by zero skips the datapath and pulses DivZero.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH,
    parameter int ITER  = MULDIV_ITER
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  muldiv_op_t       Op,
    input  logic [WIDTH-1:0] OpA,
    input  logic [WIDTH-1:0] OpB,
    input  logic             MfHi,
    input  logic             MfLo,
    output logic             DpLoad,
    output logic             DpStep,
    output muldiv_op_t       DpOp,
    output logic [WIDTH-1:0] DpA,
    output logic [WIDTH-1:0] DpB,
    input  logic [WIDTH-1:0] DpHi,
    input  logic [WIDTH-1:0] DpLo,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             Busy,
    output logic             Stall,
    output logic             Done,
    output logic             DivZero
);

    muldiv_state_t    state_q, state_d;
    muldiv_op_t       dpOp_q, dpOp_d;
    logic [WIDTH-1:0] dpA_q, dpA_d;
    logic [WIDTH-1:0] dpB_q, dpB_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             trap_q, trap_d;
    logic             cntLoad, cntDec, cntZero;

    muldiv_step_cnt #(
        .ITER(ITER)
    ) u_step_cnt (
        .Clk     (Clk),
        .Reset   (Reset),
        .loadEn_i(cntLoad),
        .decEn_i (cntDec),
        .zero_o  (cntZero)
    );

    always_comb begin
        state_d = state_q;
        dpOp_d  = dpOp_q;
        dpA_d   = dpA_q;
        dpB_d   = dpB_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        trap_d  = trap_q;
        cntLoad = 1'b0;
        cntDec  = 1'b0;
        DpLoad  = 1'b0;
        DpStep  = 1'b0;
        Done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    dpOp_d  = Op;
                    dpA_d   = OpA;
                    dpB_d   = OpB;
                    state_d = LOAD;
`ifdef MULDIV_DIVZERO_TRAP_EN
                    trap_d = isDiv(Op) && (OpB == '0);
                    if (trap_d) begin
                        state_d = WB;
                    end
`else
                    trap_d = 1'b0;
`endif
                end
            end
            LOAD: begin
                DpLoad  = 1'b1;
                cntLoad = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                DpStep = 1'b1;
                if (cntZero) begin
                    state_d = WB;
                end else begin
                    cntDec = 1'b1;
                end
            end
            WB: begin
                Done    = 1'b1;
                state_d = IDLE;
                // A trapped divide never touched the datapath, so Hi/Lo keep their old value.
                if (!trap_q) begin
                    hi_d = DpHi;
                    lo_d = DpLo;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            dpOp_q  <= OP_MULT;
            dpA_q   <= '0;
            dpB_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            trap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dpOp_q  <= dpOp_d;
            dpA_q   <= dpA_d;
            dpB_q   <= dpB_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            trap_q  <= trap_d;
        end
    end

    assign DpOp  = dpOp_q;
    assign DpA   = dpA_q;
    assign DpB   = dpB_q;
    assign Hi    = hi_q;
    assign Lo    = lo_q;
    assign Busy  = (state_q != IDLE);
    assign Stall = Busy & (MfHi | MfLo | Start);

`ifdef MULDIV_DIVZERO_TRAP_EN
    assign DivZero = (state_q == WB) & trap_q;
`else
    assign DivZero = 1'b0;
`endif

endmodule
